// File: rtl/hilo_seq.sv
// rtl/hilo_seq.sv - HI/LO multiply/divide sequencer with MULTU, DIVU, MTHI, MTLO
module hilo_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        rd_hi,
    output logic        busy,
    output logic        done,
    output logic        div0,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rdata
);

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MTHI  = 2'b10;
    localparam logic [1:0] OP_MTLO  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q,   cnt_d;
    logic [31:0] a_q,     a_d;
    logic [31:0] b_q,     b_d;
    logic [63:0] prod_q,  prod_d;
    logic [31:0] rem_q,   rem_d;
    logic [31:0] quo_q,   quo_d;
    logic [31:0] hi_q,    hi_d;
    logic [31:0] lo_q,    lo_d;
    logic        div0_q,  div0_d;

    logic        last_iter;
    logic [32:0] mul_upper;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_rem;

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: start only honoured in IDLE, divide by zero skips straight to DONE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_MULTU) begin
                        state_d = S_MUL;
                    end else if (op == OP_DIVU) begin
                        state_d = (b == 32'd0) ? S_DONE : S_DIV;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (last_iter) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: busy outside IDLE, done/div0 only in the single DONE cycle
    always_comb begin
        busy  = (state_q != S_IDLE);
        done  = (state_q == S_DONE);
        div0  = (state_q == S_DONE) && div0_q;
        hi    = hi_q;
        lo    = lo_q;
        rdata = rd_hi ? hi_q : lo_q;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= 6'd0;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            prod_q <= 64'd0;
            rem_q  <= 32'd0;
            quo_q  <= 32'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            div0_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            a_q    <= a_d;
            b_q    <= b_d;
            prod_q <= prod_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            div0_q <= div0_d;
        end
    end

    // Shift-add multiply and restoring divide steps; HI/LO only written on the final step
    always_comb begin
        cnt_d  = cnt_q;
        a_d    = a_q;
        b_d    = b_q;
        prod_d = prod_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        div0_d = div0_q;

        last_iter = (cnt_q == 6'd31);
        // Upper product half plus multiplicand when the current multiplier bit is set
        mul_upper = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, a_q} : 33'd0);
        // 33-bit partial remainder; a successful subtract always fits back into 32 bits
        div_shift = {rem_q, quo_q[31]};
        div_ge    = (div_shift >= {1'b0, b_q});
        div_rem   = div_ge ? (div_shift[31:0] - b_q) : div_shift[31:0];

        unique case (state_q)
            S_IDLE: begin
                cnt_d = 6'd0;
                if (start) begin
                    unique case (op)
                        OP_MULTU: begin
                            a_d    = a;
                            prod_d = {32'd0, b};
                            div0_d = 1'b0;
                        end
                        OP_DIVU: begin
                            b_d    = b;
                            rem_d  = 32'd0;
                            quo_d  = a;
                            div0_d = (b == 32'd0);
                            if (b == 32'd0) begin
                                hi_d = a;
                                lo_d = 32'hFFFF_FFFF;
                            end
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                cnt_d  = cnt_q + 6'd1;
                prod_d = {mul_upper, prod_q[31:1]};
                if (last_iter) begin
                    {hi_d, lo_d} = {mul_upper, prod_q[31:1]};
                end
            end
            S_DIV: begin
                cnt_d = cnt_q + 6'd1;
                rem_d = div_rem;
                quo_d = {quo_q[30:0], div_ge};
                if (last_iter) begin
                    hi_d = div_rem;
                    lo_d = {quo_q[30:0], div_ge};
                end
            end
            S_DONE:  cnt_d = 6'd0;
            default: cnt_d = 6'd0;
        endcase
    end

endmodule

// File: tb/tb_hilo_seq.sv
// tb/tb_hilo_seq.sv - table-driven and sequence checks for hilo_seq
module tb_hilo_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rd_hi;
    logic        busy;
    logic        done;
    logic        div0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rdata;

    int tests;
    int fails;

    hilo_seq dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .rd_hi (rd_hi),
        .busy  (busy),
        .done  (done),
        .div0  (div0),
        .hi    (hi),
        .lo    (lo),
        .rdata (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_div0;
        int          exp_lat;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        int n;
        int gap;
        logic [31:0] hp;
        logic [31:0] lp;
        logic        saw_done;

        tests = 0;
        fails = 0;
        start = 1'b0;
        op    = 2'b00;
        a     = 32'd0;
        b     = 32'd0;
        rd_hi = 1'b0;
        reset = 1'b0;

        // op, a, b, expected hi, expected lo, expected div0, edges after accept until done (-1: move)
        vecs[0]  = '{2'b10, 32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 32'h00000000, 1'b0, -1};
        vecs[1]  = '{2'b11, 32'h000000AA, 32'h0,        32'hCAFEF00D, 32'h000000AA, 1'b0, -1};
        vecs[2]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 32};
        vecs[3]  = '{2'b01, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 32};
        vecs[4]  = '{2'b01, 32'h12345678, 32'h0,        32'h12345678, 32'hFFFFFFFF, 1'b1, 0};
        vecs[5]  = '{2'b00, 32'd3,        32'd5,        32'd0,        32'd15,       1'b0, 32};
        vecs[6]  = '{2'b01, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0, 32};
        vecs[7]  = '{2'b00, 32'h12345678, 32'h00010000, 32'h00001234, 32'h56780000, 1'b0, 32};
        vecs[8]  = '{2'b01, 32'd7,        32'd100,      32'd7,        32'd0,        1'b0, 32};
        vecs[9]  = '{2'b00, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000, 1'b0, 32};
        vecs[10] = '{2'b01, 32'hDEADBEEF, 32'h00010000, 32'h0000BEEF, 32'h0000DEAD, 1'b0, 32};

        #3;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_div0", {63'd0, div0}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            hp = hi;
            lp = lo;
            @(negedge clk);
            start = 1'b1;
            op    = vecs[i].op;
            a     = vecs[i].a;
            b     = vecs[i].b;
            @(posedge clk);
            #1;
            start = 1'b0;
            a     = 32'h5A5A5A5A;
            b     = 32'h00000003;
            if (vecs[i].exp_lat < 0) begin
                chk($sformatf("v%0d_move_busy", i), {63'd0, busy}, 64'd0);
                chk($sformatf("v%0d_move_done", i), {63'd0, done}, 64'd0);
            end else begin
                n = 0;
                while (done !== 1'b1 && n < 40) begin
                    if (n == 16) begin
                        chk($sformatf("v%0d_hold_hilo", i), {hi, lo}, {hp, lp});
                        chk($sformatf("v%0d_mid_busy", i), {63'd0, busy}, 64'd1);
                    end
                    @(posedge clk);
                    #1;
                    n++;
                end
                chk($sformatf("v%0d_latency", i), 64'(n), 64'(vecs[i].exp_lat));
                chk($sformatf("v%0d_div0", i), {63'd0, div0}, {63'd0, vecs[i].exp_div0});
            end
            chk($sformatf("v%0d_hi", i), {32'd0, hi}, {32'd0, vecs[i].exp_hi});
            chk($sformatf("v%0d_lo", i), {32'd0, lo}, {32'd0, vecs[i].exp_lo});
            rd_hi = 1'b1;
            #1;
            chk($sformatf("v%0d_rdata_hi", i), {32'd0, rdata}, {32'd0, vecs[i].exp_hi});
            rd_hi = 1'b0;
            #1;
            chk($sformatf("v%0d_rdata_lo", i), {32'd0, rdata}, {32'd0, vecs[i].exp_lo});
            if (vecs[i].exp_lat >= 0) begin
                @(posedge clk);
                #1;
                chk($sformatf("v%0d_done_clear", i), {62'd0, done, busy}, 64'd0);
            end
        end

        // Start during MUL must be ignored
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        chk("ign_latency", 64'(n + 10), 64'd32);
        chk("ign_hilo", {hi, lo}, {32'd0, 32'd15});
        @(posedge clk);
        #1;

        // Back-to-back with start held high: done pulses 34 edges apart
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd5;
        @(posedge clk);
        #1;
        wait_done(n);
        chk("b2b_first", 64'(n), 64'd32);
        gap = 0;
        @(posedge clk);
        #1;
        gap++;
        wait_done(n);
        start = 1'b0;
        chk("b2b_gap", 64'(gap + n), 64'd34);
        @(posedge clk);
        #1;
        chk("b2b_idle", {63'd0, busy}, 64'd0);

        // Reset in the middle of MULTU aborts with no partial result
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        #1;
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_hilo", {hi, lo}, 64'd0);
        @(posedge clk);
        #1;
        chk("rst_start_ignored", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        saw_done = 1'b0;
        repeat (36) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        chk("rst_no_done", {63'd0, saw_done}, 64'd0);
        @(negedge clk);
        start = 1'b1; op = 2'b11; a = 32'h000000AA;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("rst_mtlo", {hi, lo}, {32'd0, 32'h000000AA});
        chk("rst_mtlo_busy", {63'd0, busy}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/hilo_seq.md
HILO_SEQ -- requirements
Module: hilo_seq

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: reset  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: start  input  1  request to begin an operation; sampled on rising edge.
REQ-005 SHALL have port: op  input  2  operation: 00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO.
REQ-006 SHALL have port: a  input  32  operand A (multiplicand/dividend/move source).
REQ-007 SHALL have port: b  input  32  operand B (multiplier/divisor).
REQ-008 SHALL have port: rd_hi  input  1  read select: 1 selects HI, 0 selects LO.
REQ-009 SHALL have port: busy  output  1  high while state is not IDLE; datapath stalls the PC on it.
REQ-010 SHALL have port: done  output  1  one-cycle pulse when HI/LO hold a new MULTU/DIVU result.
REQ-011 SHALL have port: div0  output  1  pulse coincident with done when DIVU had b==0.
REQ-012 SHALL have port: hi  output  32  HI register.
REQ-013 SHALL have port: lo  output  32  LO register.
REQ-014 SHALL have port: rdata  output  32  combinational rd_hi ? hi : lo, for MFHI/MFLO.

Function
REQ-015 SHALL implement states IDLE, MUL, DIV, DONE; busy = (state != IDLE).
REQ-016 SHALL accept start only in IDLE; start in MUL/DIV/DONE ignored with no side effect.
REQ-017 SHALL latch a, b and op at the accepting edge (edge 0); later operand changes have no effect.
REQ-018 MTHI/MTLO: hi (resp. lo) <= a at edge 0; state stays IDLE; busy, done, div0 stay 0.
REQ-019 MULTU: IDLE->MUL at edge 0; unsigned shift-add, one bit of b per cycle, 32 iterations on edges 1..32.
REQ-020 MULTU: at edge 32, {hi,lo} <= unsigned 64-bit a*b; state -> DONE.
REQ-021 DIVU with b!=0: IDLE->DIV at edge 0; restoring division, one quotient bit per cycle on edges 1..32.
REQ-022 DIVU with b!=0: at edge 32, lo <= a/b (unsigned quotient), hi <= a%b (remainder); state -> DONE.
REQ-023 DIVU with b==0: at edge 0, lo <= 32'hFFFFFFFF, hi <= a; state IDLE->DONE directly; div0=1 in DONE.
REQ-024 DONE lasts exactly one cycle with done=1; next edge -> IDLE.
REQ-025 A new start is accepted on the edge after DONE, i.e. back-to-back ops take 34 cycles each.
REQ-026 Iteration counter SHALL be 6 bits; working product/remainder registers internal; hi/lo SHALL NOT change during MUL/DIV until the final edge.
REQ-027 Arithmetic SHALL be unsigned only; partial-remainder width 33 bits; no overflow flag.
REQ-028 rdata SHALL reflect hi/lo combinationally, including the cycle a write lands.
REQ-029 div0 SHALL be 0 whenever done is 0.

Reset
REQ-030 reset low SHALL immediately force state IDLE, counter 0, hi=0, lo=0, busy=0, done=0, div0=0.
REQ-031 reset asserted mid-MUL/DIV SHALL abort the op with no partial result written; start is ignored while reset is low.
REQ-032 After reset release, the first rising edge with start=1 SHALL be accepted.

Verification
REQ-033 MULTU a=FFFFFFFF, b=FFFFFFFF -> busy for 33 cycles, done in cycle 33, hi=FFFFFFFE, lo=00000001.
REQ-034 DIVU a=100, b=7 -> done at cycle 33, lo=14, hi=2, div0=0; rd_hi=1 gives rdata=2.
REQ-035 DIVU a=12345678, b=0 -> DONE the cycle after start, done=div0=1, lo=FFFFFFFF, hi=12345678.
REQ-036 MULTU 3*5 started, start with op=MTHI a=DEADBEEF at cycle 10 -> ignored; final hi=0, lo=15.
REQ-037 MULTU started, reset pulsed low at cycle 16 -> hi=lo=0, busy=0, no done pulse; next MTLO a=AA -> lo=AA the next cycle.
REQ-038 MTHI a=CAFEF00D, rd_hi=1 -> rdata=CAFEF00D after one edge, busy never asserted.
